// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - FIFO-buffered 8N1 UART transmitter
module uart_tx_buffered #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       empty,
  output logic       overflow,
  output logic       busy,
  output logic       UART_TX
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;

  state_t        state, state_next;
  logic [BW-1:0] baud_cnt, baud_next, baud_inc;
  logic [2:0]    bit_idx, bit_next;
  logic [7:0]    shift_reg, shift_next;
  logic          tx_next, pop, wr_accept, baud_wrap;

  assign full      = (count == (PW+1)'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign busy      = (state != IDLE);
  assign wr_accept = wr_en && !full;
  assign baud_wrap = (baud_cnt == BW'(CLKS_PER_BIT - 1));
  assign baud_inc  = baud_wrap ? '0 : baud_cnt + 1'b1;

  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_idx;
    shift_next = shift_reg;
    tx_next    = 1'b1;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          shift_next = mem[rd_ptr];
          baud_next  = '0;
          bit_next   = '0;
          tx_next    = 1'b0;
          state_next = START;
        end
      end
      START: begin
        baud_next = baud_inc;
        tx_next   = 1'b0;
        if (baud_wrap) begin
          tx_next    = shift_reg[0];
          state_next = DATA;
        end
      end
      DATA: begin
        baud_next = baud_inc;
        tx_next   = shift_reg[0];
        if (baud_wrap) begin
          // Line value is registered, so present the next bit as the shift happens
          shift_next = {1'b0, shift_reg[7:1]};
          bit_next   = bit_idx + 1'b1;
          if (bit_idx == 3'd7) begin
            tx_next    = 1'b1;
            state_next = STOP;
          end else begin
            tx_next = shift_reg[1];
          end
        end
      end
      STOP: begin
        baud_next = baud_inc;
        if (baud_wrap) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      UART_TX   <= 1'b1;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_next;
      baud_cnt  <= baud_next;
      bit_idx   <= bit_next;
      shift_reg <= shift_next;
      UART_TX   <= tx_next;
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)       rd_ptr <= rd_ptr + 1'b1;
      case ({wr_accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_en && full) overflow <= 1'b1;
    end
  end

  // Storage needs no reset: pointers and count define what is valid
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb/tb_uart_tx_buffered.sv - self-checking bench for uart_tx_buffered
module tb_uart_tx_buffered;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full, empty, overflow, busy, UART_TX;

  uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .overflow(overflow), .busy(busy), .UART_TX(UART_TX)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Line receiver: samples the middle of each bit on falling clock edges
  logic [7:0] rx_q[$];
  int         start_q[$];
  bit         mon_active = 1'b0;
  int         mon_cnt;
  logic [9:0] mon_bits;

  always @(negedge clk) begin
    if (!reset) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (UART_TX === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
        start_q.push_back(cyc);
      end
    end else begin
      mon_cnt++;
      if (mon_cnt % CPB == CPB / 2) mon_bits[mon_cnt / CPB] = UART_TX;
      if (mon_cnt == 10 * CPB - 1) begin
        mon_active = 1'b0;
        check("frame_start_bit", mon_bits[0], 1'b0);
        check("frame_stop_bit", mon_bits[9], 1'b1);
        rx_q.push_back(mon_bits[8:1]);
      end
    end
  end

  task automatic wait_rx(input int n, input int budget);
    int t = 0;
    while (rx_q.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("rx_count_in_time", rx_q.size() >= n, 1);
  endtask

  task automatic wait_empty(input int budget);
    int t = 0;
    while (empty !== 1'b1 && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("empty_in_time", empty, 1'b1);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;   // bit i = line level during bit time i (0 = start)
  } vec_t;

  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   zero_cnt;
    bit   full_seen;
    vec_t v;

    vecs[0] = '{data: 8'h55, line: 10'h2AA};
    vecs[1] = '{data: 8'hA3, line: 10'h346};
    vecs[2] = '{data: 8'h0F, line: 10'h21E};
    vecs[3] = '{data: 8'h80, line: 10'h300};
    vecs[4] = '{data: 8'h00, line: 10'h200};
    vecs[5] = '{data: 8'hFF, line: 10'h3FE};

    reset   = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx", UART_TX, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_full", full, 1'b0);
    check("rst_empty", empty, 1'b1);
    check("rst_overflow", overflow, 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Single frames, checked cycle by cycle against the expected line pattern
    for (int n = 0; n < 6; n++) begin
      v = vecs[n];
      rx_q.delete();
      wr_en = 1'b1; wr_data = v.data;
      @(negedge clk);
      wr_en = 1'b0;
      check($sformatf("v%0d_empty_after_write", n), empty, 1'b0);
      check($sformatf("v%0d_tx_before_pop", n), UART_TX, 1'b1);
      @(negedge clk);
      check($sformatf("v%0d_busy_rise", n), busy, 1'b1);
      for (int i = 0; i < 10; i++) begin
        for (int j = 0; j < CPB; j++) begin
          check($sformatf("v%0d_line_bit%0d_cyc%0d", n, i, j), UART_TX, v.line[i]);
          @(negedge clk);
        end
      end
      check($sformatf("v%0d_busy_fall", n), busy, 1'b0);
      check($sformatf("v%0d_tx_idle", n), UART_TX, 1'b1);
      check($sformatf("v%0d_rx_count", n), rx_q.size(), 1);
      check($sformatf("v%0d_rx_data", n), rx_q[0], v.data);
      repeat (2) @(negedge clk);
    end

    // Burst of 8 on consecutive cycles
    rx_q.delete(); start_q.delete();
    full_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      @(negedge clk);
      if (full) full_seen = 1'b1;
    end
    wr_en = 1'b0;
    wait_rx(8, 8 * 41 + 50);
    check("burst_full_never", full_seen, 1'b0);
    for (int i = 0; i < 8; i++) check($sformatf("burst_rx%0d", i), rx_q[i], 8'(i));
    for (int i = 1; i < 8; i++) check($sformatf("burst_gap%0d", i), start_q[i] - start_q[i-1], 41);
    check("burst_empty_end", empty, 1'b1);
    repeat (4) @(negedge clk);

    // Overflow: one byte in flight plus 8 queued, then 0xAA must be dropped
    rx_q.delete();
    for (int i = 0; i < 9; i++) begin
      wr_en = 1'b1; wr_data = 8'h30 + 8'(i);
      @(negedge clk);
    end
    check("ovf_full", full, 1'b1);
    check("ovf_flag_before", overflow, 1'b0);
    wr_data = 8'hAA;
    @(negedge clk);
    wr_en = 1'b0;
    check("ovf_flag_set", overflow, 1'b1);
    check("ovf_still_full", full, 1'b1);
    wait_rx(9, 9 * 41 + 50);
    repeat (50) @(negedge clk);
    check("ovf_flag_sticky", overflow, 1'b1);
    check("ovf_rx_count", rx_q.size(), 9);
    for (int i = 0; i < 9; i++) check($sformatf("ovf_rx%0d", i), rx_q[i], 8'h30 + 8'(i));

    // Pointer wrap: 20 bytes in bursts of 4 each time the FIFO drains
    rx_q.delete();
    for (int b = 0; b < 5; b++) begin
      wait_empty(300);
      for (int j = 0; j < 4; j++) begin
        wr_en = 1'b1; wr_data = 8'h10 + 8'(b * 4 + j);
        @(negedge clk);
      end
      wr_en = 1'b0;
    end
    wait_rx(20, 20 * 45 + 100);
    for (int i = 0; i < 20; i++) check($sformatf("wrap_rx%0d", i), rx_q[i], 8'h10 + 8'(i));
    check("wrap_overflow_held", overflow, 1'b1);
    repeat (4) @(negedge clk);

    // Reset during DATA bit 3 of 0xF0 with two bytes queued behind it
    rx_q.delete(); start_q.delete();
    wr_en = 1'b1; wr_data = 8'hF0; @(negedge clk);
    wr_data = 8'h01; @(negedge clk);
    wr_data = 8'h02; @(negedge clk);
    wr_en = 1'b0;
    repeat (16) @(negedge clk);
    check("mid_busy", busy, 1'b1);
    check("mid_tx_bit3", UART_TX, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("rstmid_tx", UART_TX, 1'b1);
    check("rstmid_empty", empty, 1'b1);
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_overflow", overflow, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    zero_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (UART_TX !== 1'b1) zero_cnt++;
    end
    check("post_rst_line_quiet", zero_cnt, 0);
    check("post_rst_no_rx", rx_q.size(), 0);
    check("post_rst_busy", busy, 1'b0);
    wr_en = 1'b1; wr_data = 8'h5A; @(negedge clk);
    wr_en = 1'b0;
    wait_rx(1, 60);
    check("post_rst_rx", rx_q[0], 8'h5A);
    repeat (4) @(negedge clk);

    // Write on the same edge as the pop: count stays 1
    rx_q.delete();
    wr_en = 1'b1; wr_data = 8'hC3; @(negedge clk);
    wr_data = 8'h3C; @(negedge clk);
    wr_en = 1'b0;
    check("simul_empty", empty, 1'b0);
    check("simul_busy", busy, 1'b1);
    check("simul_full", full, 1'b0);
    repeat (40) @(negedge clk);
    check("simul_idle_gap_busy", busy, 1'b0);
    check("simul_idle_gap_empty", empty, 1'b0);
    @(negedge clk);
    check("simul_second_pop_empty", empty, 1'b1);
    check("simul_second_pop_busy", busy, 1'b1);
    wait_rx(2, 60);
    check("simul_rx0", rx_q[0], 8'hC3);
    check("simul_rx1", rx_q[1], 8'h3C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Buffered UART transmitter that sits directly upstream of the board's `UART_TX` pin in `top_level`. It accepts bytes from the CPU-side output logic through a write-enable interface into a small FIFO. It then serialises them as 8N1 frames (1 start bit, 8 data bits LSB-first, 1 stop bit) at a fixed bit period. This decouples single-cycle CPU output writes from the slow serial line.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per serial bit (100 MHz / 115200). Legal range is ≥ 2.
- `FIFO_DEPTH`, default 8: byte entries in the FIFO. Must be a power of two, ≥ 2.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  write strobe; enqueues `wr_data` when `full` is low.
- `wr_data`  in  8  byte to transmit.
- `full`  out  1  FIFO holds `FIFO_DEPTH` entries.
- `empty`  out  1  FIFO holds 0 entries.
- `overflow`  out  1  sticky flag, set by a write attempted while `full`.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `UART_TX`  out  1  serial output; idles high.

## Operation
- FIFO:
  - Circular buffer with `$clog2(FIFO_DEPTH)`-bit read/write pointers that wrap modulo `FIFO_DEPTH`.
  - A `$clog2(FIFO_DEPTH)+1`-bit count is the source of `full` and `empty`.
- Write acceptance:
  - A write is accepted when `wr_en` is high and the registered `full` is low.
  - A write with `full` high is dropped and sets `overflow`. The flag clears only on reset.
- Pop:
  - Occurs only on the IDLE→START transition.
  - A simultaneous accepted write and pop leaves the count unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `UART_TX`=1. If `empty` is low, pop the head byte into the shift register, clear the bit counter and baud counter, and go to START.
  - START: `UART_TX`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA:
    - `UART_TX` = shift register bit 0.
    - Every `CLKS_PER_BIT` cycles, shift right and increment the 3-bit bit index.
    - After the bit with index 7 completes, go to STOP.
  - STOP: `UART_TX`=1 for `CLKS_PER_BIT` cycles, then go to IDLE.
- Baud counter: counts 0 to `CLKS_PER_BIT-1`, then wraps to 0. The wrap is the bit-boundary event.
- `UART_TX` is registered, so there is no combinational glitch on the pin.

## Timing
- Reset values: `UART_TX`=1, `busy`=0, `full`=0, `empty`=1, `overflow`=0, FSM=IDLE, pointers=0, count=0.
- Reset mid-frame: the frame is abandoned immediately. `UART_TX` goes high asynchronously and the FIFO contents are discarded.
- Write at edge k into an empty, idle block:
  - `empty` falls after edge k.
  - The FSM pops at edge k+1.
  - `UART_TX` falls and `busy` rises after edge k+1.
- Frame length:
  - Exactly 10×`CLKS_PER_BIT` cycles from `UART_TX` falling to the end of the stop bit.
  - Each bit lasts exactly `CLKS_PER_BIT` cycles.
- Back-to-back frames: STOP always returns to IDLE for exactly 1 cycle. The inter-frame gap is therefore 10×`CLKS_PER_BIT`+1 cycles start-to-start while the FIFO is non-empty.
- `full` and `empty` update on the edge after the causing write or pop, with no lookahead.
- Throughput limit: writes faster than one byte per frame fill the FIFO. After `FIFO_DEPTH` queued bytes (plus the one in flight), further writes overflow.

## Test plan
- Single byte, `CLKS_PER_BIT`=4, write 0x55:
  - `UART_TX` falls 1 cycle after the write.
  - Line sequence is 0,1,0,1,0,1,0,1,0,1, each level held 4 cycles. The first 0 is the start bit; 0x55 is sent LSB-first.
  - `busy` stays high for 40 cycles and returns low with `UART_TX`=1.
- Burst:
  - Write 0x00–0x07 on 8 consecutive cycles with `FIFO_DEPTH`=8, `CLKS_PER_BIT`=4.
  - `full` is never set, since the first byte pops at cycle 2.
  - All 8 frames appear in order, with start bits 41 cycles apart.
  - `empty`=1 after the last pop.
- Overflow:
  - With the transmitter mid-frame and 8 bytes queued, write 0xAA.
  - `overflow`=1 and stays 1.
  - 0xAA never appears on the line; the 8 queued bytes are sent intact.
- Wrap-around: transmit 20 sequential bytes 0x10–0x23, writing in bursts of 4 each time the FIFO drains. All 20 bytes are received in order, exercising pointer wrap twice.
- Reset mid-frame:
  - Assert `reset` low during DATA bit 3 of 0xF0 with 2 more bytes queued.
  - `UART_TX`=1 immediately, and `empty`=1, `busy`=0.
  - After release, no frame is emitted until a new write.
- Simultaneous write and pop:
  - With the FSM in IDLE and 1 byte queued, write on the pop cycle.
  - Count stays 1 and both bytes are sent in order.
